// File: rtl/jtag_types_pkg.sv
// Shared types and frame-size helpers for the JTAG FIFO read arbiter.
// JTAG_FIFO_READ_PARITY_EN adds an even-parity bit to every frame.
package jtag_types_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } fifo_rd_state_t;

`ifdef JTAG_FIFO_READ_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Channel-ID field width; a single channel carries no ID at all.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 0;
   endfunction

   function automatic int frame_len(input int data_w, input int ch_w, input bit parity);
      return 2 + ch_w + data_w + (parity ? 1 : 0);
   endfunction

endpackage

// File: rtl/jtag_fifo_read_arb_if.sv
// TAP-side and FIFO-side signal bundle of the JTAG FIFO read arbiter.
// master = the arbiter, slave = the FIFOs/TAP that surround it.
interface jtag_fifo_read_arb_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 2
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
   localparam int CUR_W = (CH_W > 0) ? CH_W : 1;

   logic                         dr_shift;
   logic                         fifo_read_select;
   logic [NUM_CH-1:0]            empty;
   logic [NUM_CH*DATA_WIDTH-1:0] rdata;
   logic [NUM_CH-1:0]            rinc;
   logic                         TDO;
   logic                         busy;
   logic [CUR_W-1:0]             cur_ch;

   modport master (
      input  dr_shift, fifo_read_select, empty, rdata,
      output rinc, TDO, busy, cur_ch
   );

   modport slave (
      output dr_shift, fifo_read_select, empty, rdata,
      input  rinc, TDO, busy, cur_ch
   );
endinterface

// File: rtl/jtag_fifo_read_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
// ptr itself is the lowest priority so the previous winner yields to others.
module rr_arbiter #(
   parameter int  N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          any_req
);
   always_comb begin
      grant = '0;
      // Walk from lowest to highest priority so the last hit wins.
      for (int k = N; k >= 1; k--) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (req[idx]) begin
            grant = PW'(idx);
         end
      end
   end

   assign any_req = |req;
endmodule

// File: rtl/jtag_fifo_read_arb.sv
// Round-robin drain of NUM_CH FWFT read FIFOs into framed words shifted out on TDO.
// Define JTAG_FIFO_READ_PARITY_EN to append an even-parity bit before the stop bit.
module jtag_fifo_read_arb
   import jtag_types_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 2
) (
   input logic              TCK,
   input logic              n_rst,
   jtag_fifo_read_arb_if.master bus
);
   localparam int CH_W      = ch_width(NUM_CH);
   localparam int CUR_W     = (CH_W > 0) ? CH_W : 1;
   localparam int FRAME_LEN = frame_len(DATA_WIDTH, CH_W, PARITY_EN);
   localparam int CNT_W     = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
   localparam logic [CUR_W-1:0] PTR_RST  = CUR_W'(NUM_CH - 1);

   fifo_rd_state_t       state_reg, state_next;
   logic [FRAME_LEN-1:0] sr_reg, sr_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [CUR_W-1:0]     ptr_reg, ptr_next;
   logic [CUR_W-1:0]     grant_reg, grant_next;
   logic [CUR_W-1:0]     cur_reg, cur_next;

   logic [CUR_W-1:0]      arb_grant;
   logic                  any_req;
   logic                  shift;
   logic [NUM_CH-1:0]     req;
   logic [DATA_WIDTH-1:0] words [NUM_CH];
   logic [DATA_WIDTH-1:0] head_word;
   logic [FRAME_LEN-1:0]  frame;
   logic [NUM_CH-1:0]     rinc;
   logic                  tdo;
   logic                  busy;

   assign shift = bus.dr_shift && bus.fifo_read_select;
   assign req   = ~bus.empty;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_words
      assign words[gi] = bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(.N(NUM_CH)) u_rr_arbiter (
      .req     (req),
      .ptr     (ptr_reg),
      .grant   (arb_grant),
      .any_req (any_req)
   );

   always_comb begin
      head_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(grant_reg) == i) begin
            head_word = words[i];
         end
      end
   end

   // Frame, LSB first: start(1), ID, data, [parity], stop(0 via default).
   always_comb begin
      logic par;
      frame = '0;
      frame[0] = 1'b1;
      par = ^head_word;
      for (int i = 0; i < CH_W; i++) begin
         frame[1+i] = grant_reg[i];
         par        = par ^ grant_reg[i];
      end
      for (int i = 0; i < DATA_WIDTH; i++) begin
         frame[1+CH_W+i] = head_word[i];
      end
`ifdef JTAG_FIFO_READ_PARITY_EN
      frame[1+CH_W+DATA_WIDTH] = par;
`endif
   end

   always_ff @(posedge TCK or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= IDLE;
         sr_reg    <= '0;
         cnt_reg   <= '0;
         ptr_reg   <= PTR_RST;
         grant_reg <= '0;
         cur_reg   <= '0;
      end else begin
         state_reg <= state_next;
         sr_reg    <= sr_next;
         cnt_reg   <= cnt_next;
         ptr_reg   <= ptr_next;
         grant_reg <= grant_next;
         cur_reg   <= cur_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sr_next    = sr_reg;
      cnt_next   = cnt_reg;
      ptr_next   = ptr_reg;
      grant_next = grant_reg;
      cur_next   = cur_reg;
      rinc       = '0;
      tdo        = 1'b0;
      busy       = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (any_req) begin
               grant_next = arb_grant;
               state_next = LOAD;
            end
         end
         LOAD: begin
            busy    = 1'b1;
            sr_next = frame;
            for (int i = 0; i < NUM_CH; i++) begin
               rinc[i] = (int'(grant_reg) == i);
            end
            ptr_next   = grant_reg;
            cur_next   = grant_reg;
            cnt_next   = '0;
            state_next = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            tdo  = sr_reg[0];
            // A deasserted shift simply freezes the frame in place.
            if (shift) begin
               sr_next  = sr_reg >> 1;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_BIT) begin
                  cnt_next = '0;
                  if (any_req) begin
                     grant_next = arb_grant;
                     state_next = LOAD;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.rinc   = rinc;
   assign bus.TDO    = tdo;
   assign bus.busy   = busy;
   assign bus.cur_ch = (CH_W > 0) ? cur_reg : '0;

endmodule

// File: tb/tb_jtag_fifo_read_arb.sv
// Randomized and directed bench for jtag_fifo_read_arb with a queue-based frame model.
// Honours JTAG_FIFO_READ_PARITY_EN the same way the design does.
module tb_jtag_fifo_read_arb;
   localparam int DW  = 8;
   localparam int NCH = 2;
   localparam int CHW = 1;
`ifdef JTAG_FIFO_READ_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FLEN = 2 + CHW + DW + (PAR ? 1 : 0);

   logic TCK = 1'b0;
   logic n_rst;
   always #5 TCK = ~TCK;

   jtag_fifo_read_arb_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

   jtag_fifo_read_arb #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
      .TCK   (TCK),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Model: per-channel FIFO contents, frame bits still owed, pending pop.
   logic [DW-1:0] fq [NCH][$];
   bit            m_bits [$];
   bit            m_pending;
   int            m_pend_ch;
   int            m_ptr;
   int            m_cur;
   int            grant_log [$];
   logic [31:0]   frame_cap;
   int            cap_n;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick();
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (m_ptr + k) % NCH;
         if (fq[c].size() > 0) return c;
      end
      return -1;
   endfunction

   function automatic bit any_queued();
      for (int c = 0; c < NCH; c++) if (fq[c].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic build_frame(input int ch, input logic [DW-1:0] w);
      bit par;
      par = 1'b0;
      m_bits.delete();
      m_bits.push_back(1'b1);
      for (int i = 0; i < CHW; i++) begin
         m_bits.push_back(bit'((ch >> i) & 1));
         par ^= bit'((ch >> i) & 1);
      end
      for (int i = 0; i < DW; i++) begin
         m_bits.push_back(w[i]);
         par ^= w[i];
      end
      if (PAR) m_bits.push_back(par);
      m_bits.push_back(1'b0);
   endtask

   task automatic arbitrate();
      int c;
      c = rr_pick();
      if (c >= 0) begin
         m_pending = 1'b1;
         m_pend_ch = c;
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_pending = 1'b0;
      m_ptr     = NCH - 1;
      m_cur     = 0;
      grant_log.delete();
   endtask

   task automatic drive_fifos();
      for (int c = 0; c < NCH; c++) begin
         bus.empty[c] = (fq[c].size() == 0);
         bus.rdata[c*DW +: DW] = (fq[c].size() > 0) ? fq[c][0] : '0;
      end
   endtask

   task automatic model_step(input bit sh);
      logic [NCH-1:0] exp_rinc;
      logic [DW-1:0]  w;
      exp_rinc = '0;
      if (m_pending) begin
         exp_rinc[m_pend_ch] = 1'b1;
         check("rinc_load", bus.rinc, exp_rinc);
         check("tdo_load", bus.TDO, 0);
         check("busy_load", bus.busy, 1);
         w = fq[m_pend_ch].pop_front();
         grant_log.push_back(m_pend_ch);
         $display("frame ch=%0d data=%02h", m_pend_ch, w);
         build_frame(m_pend_ch, w);
         m_ptr     = m_pend_ch;
         m_cur     = m_pend_ch;
         m_pending = 1'b0;
         frame_cap = '0;
         cap_n     = 0;
      end else if (m_bits.size() > 0) begin
         check("tdo_bit", bus.TDO, m_bits[0]);
         check("busy_shift", bus.busy, 1);
         check("rinc_shift", bus.rinc, 0);
         check("cur_ch", bus.cur_ch, m_cur);
         if (sh) begin
            frame_cap[cap_n] = bus.TDO;
            cap_n++;
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) arbitrate();
         end
      end else begin
         check("tdo_idle", bus.TDO, 0);
         check("busy_idle", bus.busy, 0);
         check("rinc_idle", bus.rinc, 0);
         arbitrate();
      end
   endtask

   task automatic cycle_body(input bit ds, input bit sel);
      bus.dr_shift         = ds;
      bus.fifo_read_select = sel;
      drive_fifos();
      #1;
      model_step(ds & sel);
   endtask

   task automatic cycle(input bit ds, input bit sel);
      @(negedge TCK);
      cycle_body(ds, sel);
   endtask

   task automatic reset_check_release();
      n_rst = 1'b0;
      #1;
      check("rst_tdo", bus.TDO, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rinc", bus.rinc, 0);
      check("rst_cur_ch", bus.cur_ch, 0);
      model_reset();
      repeat (2) @(posedge TCK);
      @(negedge TCK);
      n_rst = 1'b1;
      cycle_body(1'b0, 1'b0);
   endtask

   initial begin
      int guard;
      logic [FLEN-1:0] exp_seq;

      bus.dr_shift         = 1'b0;
      bus.fifo_read_select = 1'b0;
      bus.empty            = '1;
      bus.rdata            = '0;
      model_reset();
      n_rst = 1'b1;
      #1;
      reset_check_release();

      // Idle with shift held high: nothing may move.
      repeat (20) cycle(1'b1, 1'b1);

      // Single word on ch1.
      fq[1].push_back(8'hA5);
      repeat (2 + FLEN + 2) cycle(1'b1, 1'b1);
      exp_seq = PAR ? FLEN'(12'b011010010111) : FLEN'(11'b01010010111);
      check("a5_seq", frame_cap[FLEN-1:0], exp_seq);
      check("a5_len", cap_n, FLEN);
      check("a5_grant", grant_log[grant_log.size()-1], 1);

      // Both channels busy: grants must alternate.
      grant_log.delete();
      fq[0].push_back(8'h01); fq[0].push_back(8'h01);
      fq[1].push_back(8'h02); fq[1].push_back(8'h02);
      repeat (4 * (FLEN + 1) + 4) cycle(1'b1, 1'b1);
      check("rr_count", grant_log.size(), 4);
      for (int i = 0; i < 4; i++) check("rr_order", grant_log[i], i % 2);

      // Pause after the 4th bit, then resume.
      fq[0].push_back(8'h5C);
      repeat (2 + 4) cycle(1'b1, 1'b1);
      repeat (5) cycle(1'b0, 1'b1);
      repeat (FLEN - 4 + 2) cycle(1'b1, 1'b1);
      check("pause_len", cap_n, FLEN);

      // Reset while the 6th bit is on TDO; ch0 must win after release.
      fq[0].push_back(8'h3E);
      repeat (2 + 5) cycle(1'b1, 1'b1);
      check("pre_rst_busy", bus.busy, 1);
      fq[1].push_back(8'h77);
      fq[0].push_back(8'h11);
      reset_check_release();
      repeat (3) cycle(1'b1, 1'b1);
      check("post_rst_grant", grant_log[0], 0);

`ifdef JTAG_FIFO_READ_PARITY_EN
      guard = 0;
      while ((any_queued() || m_pending || m_bits.size() > 0) && guard < 500) begin
         cycle(1'b1, 1'b1);
         guard++;
      end
      fq[1].push_back(8'h03);
      repeat (2 + FLEN + 2) cycle(1'b1, 1'b1);
      check("par_seq", frame_cap[FLEN-1:0], FLEN'(12'b010000001111));
      check("par_len", cap_n, 12);
`endif

      // Randomized traffic with pauses and deselects.
      for (int n = 0; n < 600; n++) begin
         @(negedge TCK);
         if ($urandom_range(0, 3) == 0) begin
            int c;
            c = $urandom_range(0, NCH - 1);
            if (fq[c].size() < 4) fq[c].push_back(DW'($urandom));
         end
         cycle_body($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9);
      end

      guard = 0;
      while ((any_queued() || m_pending || m_bits.size() > 0) && guard < 2000) begin
         cycle(1'b1, 1'b1);
         guard++;
      end
      check("drain_done", guard < 2000, 1);
      repeat (3) cycle(1'b1, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
